// File: rtl/c1541_track_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_track_sched_if
//  Description : Signal bundle between the 1541 drive logic / track engine
//                and the head-position and track-buffer scheduler.
//                master : drive logic and track engine side
//                         (drives mtr, stp, act, buff_we, disk_change, busy)
//                slave  : scheduler side
//                         (drives track, ht_pos, tr00_sense_n, save_req,
//                          load_req, dirty, sched_idle)
//  Revision    : 1.0  initial release
// ============================================================================
interface c1541_track_sched_if;
    logic       mtr;           // spindle motor on
    logic [1:0] stp;           // stepper phase
    logic       act;           // activity LED
    logic       buff_we;       // track buffer written this cycle
    logic       disk_change;   // new image inserted (level)
    logic       busy;          // track engine busy
    logic [5:0] track;         // committed track held in the buffer
    logic [6:0] ht_pos;        // live half-track position
    logic       tr00_sense_n;  // low on track 0
    logic       save_req;      // one-cycle write-back request
    logic       load_req;      // one-cycle load request
    logic       dirty;         // buffer modified since last load/save
    logic       sched_idle;    // scheduler idle

    modport master (
        output mtr, stp, act, buff_we, disk_change, busy,
        input  track, ht_pos, tr00_sense_n, save_req, load_req, dirty, sched_idle
    );

    modport slave (
        input  mtr, stp, act, buff_we, disk_change, busy,
        output track, ht_pos, tr00_sense_n, save_req, load_req, dirty, sched_idle
    );
endinterface
`default_nettype wire

// File: rtl/c1541_track_sched.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_track_sched
//  Description : Head-position controller and track-buffer scheduler for one
//                1541 drive. Decodes stepper phases into a half-track
//                position, waits for the head to settle, then writes back a
//                modified buffer before loading the newly selected track.
//  Ports       : clk_c1541 - drive clock
//                reset     - synchronous, active-high
//                bus       - c1541_track_sched_if.slave (stepper, activity,
//                            buffer-write and engine handshake signals)
//  Option      : C1541_STEP_SETTLE_EN - when defined, SETTLE waits
//                SETTLE_CYCLES after the last step; otherwise SETTLE lasts
//                a single cycle and no counter is built.
//  Revision    : 1.0  initial release
// ============================================================================
module c1541_track_sched #(
    parameter int HT_RESET      = 36,
    parameter int HT_MIN        = 1,
    parameter int HT_MAX        = 80,
    parameter int SETTLE_CYCLES = 32000
) (
    input  wire logic            clk_c1541,
    input  wire logic            reset,
    c1541_track_sched_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_SETTLE       = 3'd1,
        S_SAVE         = 3'd2,
        S_WAIT_SAVE_HI = 3'd3,
        S_WAIT_SAVE_LO = 3'd4,
        S_LOAD         = 3'd5,
        S_WAIT_LOAD_HI = 3'd6,
        S_WAIT_LOAD_LO = 3'd7
    } state_t;

    localparam logic [6:0] c_ht_reset = 7'(HT_RESET);
    localparam logic [6:0] c_ht_min   = 7'(HT_MIN);
    localparam logic [6:0] c_ht_max   = 7'(HT_MAX);
    localparam logic [5:0] c_tr_reset = 6'(HT_RESET >> 1);

    state_t     r_state;
    logic [1:0] r_stp;
    logic       r_act;
    logic [6:0] r_ht_pos;
    logic [5:0] r_track;
    logic       r_dirty;
    logic       r_no_load;   // current save was started by activity, not a seek
    logic       r_dc_pend;   // disk change seen, load owed once it drops

    logic       w_up;
    logic       w_dn;
    logic       w_step;
    logic       w_act_fall;
    logic [5:0] w_ht_track;
    logic       w_same;
    logic       w_settle_done;

    // Phase sequence 0->2->1->3->0 moves the head inward (up).
    assign w_up = bus.mtr && (((r_stp == 2'd0) && (bus.stp == 2'd2)) ||
                              ((r_stp == 2'd2) && (bus.stp == 2'd1)) ||
                              ((r_stp == 2'd1) && (bus.stp == 2'd3)) ||
                              ((r_stp == 2'd3) && (bus.stp == 2'd0)));
    assign w_dn = bus.mtr && (((r_stp == 2'd0) && (bus.stp == 2'd3)) ||
                              ((r_stp == 2'd2) && (bus.stp == 2'd0)) ||
                              ((r_stp == 2'd1) && (bus.stp == 2'd2)) ||
                              ((r_stp == 2'd3) && (bus.stp == 2'd1)));
    assign w_step     = w_up | w_dn;
    assign w_act_fall = r_act & ~bus.act;
    assign w_ht_track = r_ht_pos[6:1];
    assign w_same     = (w_ht_track == r_track);

`ifdef C1541_STEP_SETTLE_EN
    localparam int             c_cw          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_settle_init = c_cw'(SETTLE_CYCLES - 1);
    logic [c_cw-1:0] r_settle;

    // A step in the final settle cycle still restarts the wait.
    assign w_settle_done = !w_step && (r_settle == '0);
`else
    // Without the settle counter the parameter only keeps both builds
    // instantiable with the same parameter list.
    logic w_unused_settle;
    assign w_unused_settle = (SETTLE_CYCLES > 1);
    assign w_settle_done   = 1'b1;
`endif

    // Head position tracks the stepper independently of the scheduler so
    // steps during I/O are never lost.
    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            r_stp    <= bus.stp;
            r_ht_pos <= c_ht_reset;
        end else begin
            r_stp <= bus.stp;
            if (w_up && (r_ht_pos != c_ht_max)) begin
                r_ht_pos <= r_ht_pos + 7'd1;
            end else if (w_dn && (r_ht_pos != c_ht_min)) begin
                r_ht_pos <= r_ht_pos - 7'd1;
            end
        end
    end

    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_act     <= 1'b0;
            r_track   <= c_tr_reset;
            r_dirty   <= 1'b0;
            r_no_load <= 1'b0;
            r_dc_pend <= 1'b0;
`ifdef C1541_STEP_SETTLE_EN
            r_settle  <= '0;
`endif
        end else begin
            r_act <= bus.act;
            if (bus.buff_we) begin
                r_dirty <= 1'b1;
            end

            if (bus.disk_change) begin
                // The old buffer belongs to the removed image: never save it.
                r_state   <= S_IDLE;
                r_dc_pend <= 1'b1;
                r_no_load <= 1'b0;
            end else if (r_dc_pend) begin
                r_dc_pend <= 1'b0;
                r_state   <= S_LOAD;
                r_track   <= w_ht_track;
                r_dirty   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_step || !w_same) begin
                            r_state  <= S_SETTLE;
`ifdef C1541_STEP_SETTLE_EN
                            r_settle <= c_settle_init;
`endif
                        end else if (w_act_fall && r_dirty) begin
                            r_state   <= S_SAVE;
                            r_no_load <= 1'b1;
                            r_dirty   <= 1'b0;
                        end
                    end
                    S_SETTLE: begin
                        if (w_settle_done) begin
                            if (w_same) begin
                                r_state <= S_IDLE;
                            end else if (r_dirty) begin
                                r_state   <= S_SAVE;
                                r_no_load <= 1'b0;
                                r_dirty   <= 1'b0;
                            end else begin
                                r_state <= S_LOAD;
                                r_track <= w_ht_track;
                                r_dirty <= 1'b0;
                            end
                        end
`ifdef C1541_STEP_SETTLE_EN
                        else if (w_step) begin
                            r_settle <= c_settle_init;
                        end else begin
                            r_settle <= r_settle - c_cw'(1);
                        end
`endif
                    end
                    S_SAVE:         r_state <= S_WAIT_SAVE_HI;
                    S_WAIT_SAVE_HI: if (bus.busy) r_state <= S_WAIT_SAVE_LO;
                    S_WAIT_SAVE_LO: begin
                        if (!bus.busy) begin
                            if (r_no_load) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_LOAD;
                                r_track <= w_ht_track;
                                r_dirty <= 1'b0;
                            end
                        end
                    end
                    S_LOAD:         r_state <= S_WAIT_LOAD_HI;
                    S_WAIT_LOAD_HI: if (bus.busy) r_state <= S_WAIT_LOAD_LO;
                    S_WAIT_LOAD_LO: if (!bus.busy) r_state <= S_IDLE;
                    default:        r_state <= S_IDLE;
                endcase
            end

            if (bus.disk_change) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // Requests are decoded straight from the state register, so each is
    // high for exactly the one cycle spent in SAVE or LOAD.
    assign bus.track        = r_track;
    assign bus.ht_pos       = r_ht_pos;
    assign bus.tr00_sense_n = |r_ht_pos[6:1];
    assign bus.save_req     = (r_state == S_SAVE);
    assign bus.load_req     = (r_state == S_LOAD);
    assign bus.dirty        = r_dirty;
    assign bus.sched_idle   = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: doc/c1541_track_sched.md
Name: c1541_track_sched

Overview:
- Head-position controller and track-buffer scheduler for one 1541 drive, in the clk_c1541 domain.
- Decodes the stepper phase outputs of the drive logic into a half-track position and waits for the head to settle.
- Sequences write-back (save) of a modified track buffer before loading the newly selected track, using a busy handshake with the track-buffer/SD engine.
- Replaces ad-hoc per-step save pulses, so rapid seeks do not cause one SD transfer per track crossed.

Parameters:
- HT_RESET, 36: half-track position after reset (track 18).
- HT_MIN, 1: lowest half-track reachable.
- HT_MAX, 80: highest half-track reachable.
- SETTLE_CYCLES, 32000: head settle delay in clk_c1541 cycles (1 ms at 32 MHz).

Ports:
- clk_c1541  in  1  drive clock.
- reset  in  1  synchronous, active-high.
- mtr  in  1  spindle motor on; stepping is ignored while low.
- stp  in  2  stepper phase from drive logic.
- act  in  1  drive activity LED signal.
- buff_we  in  1  track buffer written this cycle.
- disk_change  in  1  level; new image inserted.
- busy  in  1  track engine busy (SD transfer in progress).
- track  out  6  committed track currently held in the buffer (0-40).
- ht_pos  out  7  live half-track position.
- tr00_sense_n  out  1  low when ht_pos[6:1]==0.
- save_req  out  1  one-cycle pulse: write buffer back as `track`.
- load_req  out  1  one-cycle pulse: load `track` into the buffer.
- dirty  out  1  buffer modified since last load/save.
- sched_idle  out  1  FSM in IDLE.

Behaviour:
- Reset values:
  - ht_pos=HT_RESET; track=HT_RESET>>1.
  - save_req=0, load_req=0, dirty=0; state=IDLE, sched_idle=1.
  - stp_r=stp; act_r=0; settle counter=0.
- Step decode, on registered stp_r vs stp, only when mtr=1:
  - Up transitions 0->2, 2->1, 1->3, 3->0: ht_pos+1, saturating at HT_MAX.
  - Down transitions 0->3, 2->0, 1->2, 3->1: ht_pos-1, saturating at HT_MIN.
  - Any other change, or no change, does not move ht_pos.
  - ht_pos updates in the cycle after stp changes.
- Dirty flag:
  - Set by buff_we.
  - Cleared in the cycle save_req pulses, and whenever disk_change=1; disk_change wins over buff_we.
- FSM states: IDLE, SETTLE, SAVE, WAIT_SAVE_HI, WAIT_SAVE_LO, LOAD, WAIT_LOAD_HI, WAIT_LOAD_LO.
- IDLE:
  - A step event -> SETTLE with counter=SETTLE_CYCLES-1.
  - Else act falling edge with dirty=1 -> SAVE, flagged no_load.
- SETTLE:
  - Counter decrements each cycle; any further step reloads it.
  - At 0:
    - ht_pos[6:1]==track -> IDLE (a half-step within the same track causes no I/O).
    - dirty -> SAVE.
    - Otherwise -> LOAD.
- SAVE: save_req=1 for one cycle, track unchanged -> WAIT_SAVE_HI.
- WAIT_SAVE_HI: wait for busy=1.
- WAIT_SAVE_LO: wait for busy=0; then -> IDLE if no_load, else -> LOAD.
- LOAD: track<=ht_pos[6:1] and load_req=1 in the same cycle; dirty<=0 -> WAIT_LOAD_HI.
- WAIT_LOAD_HI / WAIT_LOAD_LO: as the save wait states; then -> IDLE. If ht_pos[6:1]!=track, the FSM returns via SETTLE.
- Steps during SAVE, LOAD and wait states update ht_pos only; they are re-evaluated when the FSM returns to IDLE (IDLE compares ht_pos[6:1]!=track -> SETTLE).
- disk_change=1 in any state: dirty cleared, no save issued, FSM -> LOAD after disk_change falls. The saved track number is never sent for the new image.
- Reset mid-operation: everything returns to reset values the next cycle; a pending save is dropped.
- save_req and load_req are never high together. Each is asserted at most once per handshake.

Optional Feature:
- Macro C1541_STEP_SETTLE_EN.
- Defined: SETTLE state behaves as above.
- Undefined:
  - SETTLE lasts exactly one cycle (the counter is not built).
  - Every track change triggers its own save/load at the next IDLE evaluation.
  - Steps arriving during I/O are coalesced only by the IDLE recheck.

Test Plan:
- Reset, mtr=1, stp sequence 0->2->1->3 -> ht_pos 36->39; after SETTLE_CYCLES, load_req pulse with track=19; busy pulse -> sched_idle=1.
- Single up-step 36->37 (same track 18), dirty=1 -> no save_req, no load_req; track stays 18.
- buff_we pulse, then 4 up-steps -> save_req with track=18; busy 1 then 0 -> load_req with track=20; dirty=0.
- 20 steps spaced SETTLE_CYCLES/2 apart -> exactly one save/load pair, after the last step.
- dirty=1, act 1->0 with no step -> one save_req, no load_req; FSM returns to IDLE.
- disk_change during WAIT_SAVE_HI -> dirty=0, load_req after disk_change falls; no further save_req.
- Down-steps from 2 to below HT_MIN -> ht_pos saturates at 1, tr00_sense_n=0.
